csa_arbiter: RTL and testbench
==============================

Name: csa_arbiter

Overview:
Shares one combinational 16-bit carry select adder (add/subtract via mod, carry-out "overflow") between two requesters. Each requester uses a valid/ready handshake. The block round-robin arbitrates, latches the winner's operands, and drives them onto the adder for a programmable settle time. It then captures Y and overflow into a response register that is held under backpressure. It sits between the requesting datapath blocks and the single adder instance.

Parameters:
WIDTH, 16, operand/result width; must match the adder instance.
SETTLE, 2, cycles operands are held on the adder before capture (1..15); covers adder propagation delay.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  2  per-requester request valid (bit i = requester i).
req_ready  output  2  per-requester accept; one-hot or zero.
req0_a, req0_b  input  WIDTH  requester 0 operands.
req0_mod  input  1  requester 0 op: 0 = A+B, 1 = A-B.
req1_a, req1_b  input  WIDTH  requester 1 operands.
req1_mod  input  1  requester 1 op.
csa_a, csa_b  output  WIDTH  operands to the adder.
csa_mod  output  1  mod to the adder.
csa_y  input  WIDTH  adder result.
csa_ovf  input  1  adder overflow/carry-out.
rsp_valid  output  1  response valid.
rsp_ready  input  1  response consumer accept.
rsp_id  output  1  requester that owns the response.
rsp_y  output  WIDTH  captured result.
rsp_ovf  output  1  captured overflow.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state = IDLE; every output and internal register is 0, including req_ready, rsp_*, csa_a, csa_b, csa_mod and busy; priority pointer = 0 (requester 0 favoured). Asserting reset mid-operation abandons the transaction; no response is produced.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready is combinational: bit i is high when req_valid[i] is high and i wins arbitration.
  - Only one requester is valid: it wins.
  - Both are valid: the requester selected by the priority pointer wins.
  - A handshake is req_valid[i] & req_ready[i]. On a handshake, latch that requester's a, b and mod into the csa_* registers and its id into an id register; clear the settle counter; go to ISSUE.
  - On a handshake, the priority pointer is set to the other requester, so it alternates strictly under contention.
- ISSUE:
  - csa_a, csa_b and csa_mod are held stable. req_ready = 0.
  - The settle counter increments each cycle.
  - When the counter reaches SETTLE-1, capture csa_y into rsp_y and csa_ovf into rsp_ovf, set rsp_valid = 1, and go to RESP.
  - Capture therefore occurs SETTLE cycles after the handshake edge.
- RESP:
  - rsp_valid, rsp_id, rsp_y and rsp_ovf are held stable until rsp_valid & rsp_ready.
  - On that cycle clear rsp_valid and go to IDLE. req_ready = 0 throughout RESP.
  - The next grant is possible on the cycle after returning to IDLE. Minimum issue interval is SETTLE+2 cycles with rsp_ready tied high.
- csa_* registers keep the last operands after a transaction; they are not cleared in IDLE.
- Arithmetic: the block performs no arithmetic. rsp_y and rsp_ovf are exactly the adder outputs sampled at capture; mod is passed through unchanged.
- A request whose req_valid drops before its grant is simply not served. The pointer only changes on a handshake.
- busy = (state != IDLE).

Test Plan:
1. Reset then idle: rst_n low for 3 cycles, then high with no requests → all outputs 0, busy 0, req_ready 2'b00.
2. Single add, requester 0: req0_a=0x000C, req0_b=0x000A, mod=0, SETTLE=2 → handshake at cycle t; rsp_valid at t+2 with rsp_y=0x0016, rsp_ovf=0, rsp_id=0.
3. Carry-out, requester 1: a=0xC444, b=0xCB52, mod=0 → rsp_y=0x8F96, rsp_ovf=1, rsp_id=1.
4. Contention fairness: both valid continuously with distinct operands, rsp_ready=1 → grants alternate 0,1,0,1 over 4 transactions; each rsp_id and rsp_y matches the granted requester's operands.
5. Backpressure: requester 0 subtract a=0xFFFE, b=0xFFFF, mod=1, rsp_ready low for 5 cycles → rsp_valid and rsp_y (adder result for 0xFFFE-0xFFFF) held stable; req_ready 0 throughout; released on the first rsp_ready cycle.
6. Reset mid-ISSUE: assert rst_n low one cycle after a grant → rsp_valid never rises; outputs 0 immediately; after release, the first grant goes to requester 0 when both are valid.

Source files
------------

// File: rtl/csa_arbiter_if.sv
// Bundle of the request, adder and response signals of csa_arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface csa_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_mod;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_mod;
  logic [WIDTH-1:0] csa_a;
  logic [WIDTH-1:0] csa_b;
  logic             csa_mod;
  logic [WIDTH-1:0] csa_y;
  logic             csa_ovf;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_ovf;
  logic             busy;

  modport slave (
    input  req_valid, req0_a, req0_b, req0_mod, req1_a, req1_b, req1_mod,
    input  csa_y, csa_ovf, rsp_ready,
    output req_ready, csa_a, csa_b, csa_mod,
    output rsp_valid, rsp_id, rsp_y, rsp_ovf, busy
  );

  modport master (
    output req_valid, req0_a, req0_b, req0_mod, req1_a, req1_b, req1_mod,
    output csa_y, csa_ovf, rsp_ready,
    input  req_ready, csa_a, csa_b, csa_mod,
    input  rsp_valid, rsp_id, rsp_y, rsp_ovf, busy
  );
endinterface

// File: rtl/csa_arbiter.sv
// Round-robin arbiter sharing one external carry select adder between two
// requesters: grant, hold operands for SETTLE cycles, capture, hold response.
module csa_arbiter #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 2
) (
  input logic          clk,
  input logic          rst_n,
  csa_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_q, state_d;
  logic             ptr_q;
  logic             id_q;
  logic [3:0]       cnt_q;
  logic [WIDTH-1:0] a_q, b_q, y_q;
  logic             mod_q, ovf_q, vld_q;

  logic [1:0]       grant;
  logic             handshake;
  logic             capture;
  logic             rsp_done;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    grant    = 2'b00;
    capture  = 1'b0;
    rsp_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A lone requester always wins; under contention the pointer decides.
        grant[0] = bus.req_valid[0] & (~bus.req_valid[1] | ~ptr_q);
        grant[1] = bus.req_valid[1] & (~bus.req_valid[0] |  ptr_q);
        if (|grant) state_d = ISSUE;
      end
      ISSUE: begin
        if (cnt_q == SETTLE_LAST) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is only ever asserted alongside req_valid, so any grant is a handshake.
  assign handshake = |grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
      id_q  <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      mod_q <= 1'b0;
      y_q   <= '0;
      ovf_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      if (handshake) begin
        a_q   <= grant[1] ? bus.req1_a   : bus.req0_a;
        b_q   <= grant[1] ? bus.req1_b   : bus.req0_b;
        mod_q <= grant[1] ? bus.req1_mod : bus.req0_mod;
        id_q  <= grant[1];
        ptr_q <= ~grant[1];
        cnt_q <= '0;
      end else if (state_q == ISSUE) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (capture) begin
        y_q   <= bus.csa_y;
        ovf_q <= bus.csa_ovf;
        vld_q <= 1'b1;
      end else if (rsp_done) begin
        vld_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.csa_a     = a_q;
  assign bus.csa_b     = b_q;
  assign bus.csa_mod   = mod_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_y     = y_q;
  assign bus.rsp_ovf   = ovf_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_csa_arbiter.sv
// Directed bench for csa_arbiter: models the external adder and checks grants,
// latency, fairness, backpressure and mid-transaction reset.
module tb_csa_arbiter;

  localparam int WIDTH = 16;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  csa_arbiter_if #(.WIDTH(WIDTH)) bus ();

  csa_arbiter #(.WIDTH(WIDTH), .SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External adder: A+B, or A-B as A + ~B + 1; ovf is the carry-out.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, bus.csa_a}
             + {1'b0, (bus.csa_mod ? ~bus.csa_b : bus.csa_b)}
             + {{WIDTH{1'b0}}, bus.csa_mod};
  assign bus.csa_y   = sum[WIDTH-1:0];
  assign bus.csa_ovf = sum[WIDTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives req_valid until a grant appears (bounded), then clocks the handshake edge.
  task automatic issue(input logic [1:0] v, output logic [1:0] g);
    int n;
    n = 0;
    bus.req_valid = v;
    #1;
    while (bus.req_ready == 2'b00 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    g = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
  endtask

  task automatic wait_rsp(output bit seen);
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    seen = bus.rsp_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b00 || bus.busy !== 1'b0) $display("FAIL reset_ctrl: req_ready=%b busy=%b want 00/0", bus.req_ready, bus.busy);
    else n_pass++;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_y} !== 19'd0) $display("FAIL reset_rsp: valid=%b id=%b ovf=%b y=%h want all 0", bus.rsp_valid, bus.rsp_id, bus.rsp_ovf, bus.rsp_y);
    else n_pass++;
    n_checks++;
    if ({bus.csa_mod, bus.csa_a, bus.csa_b} !== 33'd0) $display("FAIL reset_csa: a=%h b=%h mod=%b want 0", bus.csa_a, bus.csa_b, bus.csa_mod);
    else n_pass++;
  endtask

  task automatic test_single_add;
    logic [1:0] g;
    bit seen;
    int t;
    bus.req0_a = 16'h000C; bus.req0_b = 16'h000A; bus.req0_mod = 1'b0;
    issue(2'b01, g);
    t = cyc;
    n_checks++;
    if (g !== 2'b01) $display("FAIL add_grant: got %b want 01", g);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.csa_a !== 16'h000C || bus.csa_b !== 16'h000A || bus.csa_mod !== 1'b0)
      $display("FAIL add_issue: busy=%b a=%h b=%h mod=%b want 1/000c/000a/0", bus.busy, bus.csa_a, bus.csa_b, bus.csa_mod);
    else n_pass++;
    wait_rsp(seen);
    n_checks++;
    if (!seen || cyc - t != 2) $display("FAIL add_latency: seen=%0d cycles=%0d want 1/2", seen, cyc - t);
    else n_pass++;
    n_checks++;
    if (bus.rsp_y !== 16'h0016 || bus.rsp_ovf !== 1'b0 || bus.rsp_id !== 1'b0)
      $display("FAIL add_rsp: y=%h ovf=%b id=%b want 0016/0/0", bus.rsp_y, bus.rsp_ovf, bus.rsp_id);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL add_done: valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    else n_pass++;
  endtask

  task automatic test_carry;
    logic [1:0] g;
    bit seen;
    bus.req1_a = 16'hC444; bus.req1_b = 16'hCB52; bus.req1_mod = 1'b0;
    issue(2'b10, g);
    wait_rsp(seen);
    n_checks++;
    if (g !== 2'b10 || !seen) $display("FAIL carry_grant: grant=%b seen=%0d want 10/1", g, seen);
    else n_pass++;
    n_checks++;
    if (bus.rsp_y !== 16'h8F96 || bus.rsp_ovf !== 1'b1 || bus.rsp_id !== 1'b1)
      $display("FAIL carry_rsp: y=%h ovf=%b id=%b want 8f96/1/1", bus.rsp_y, bus.rsp_ovf, bus.rsp_id);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [15:0] exp_y;
    logic        exp_o;
    int n, prev;
    bus.req0_a = 16'h1000; bus.req0_b = 16'h0234; bus.req0_mod = 1'b0;  // 0x1234, no carry
    bus.req1_a = 16'h5000; bus.req1_b = 16'h0001; bus.req1_mod = 1'b1;  // 0x4FFF, carry-out 1
    bus.req_valid = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      #1;
      while (bus.req_ready == 2'b00 && n < 20) begin
        @(posedge clk); #1; n++;
      end
      n_checks++;
      if (bus.req_ready !== exp_g[k]) $display("FAIL rr_grant%0d: got %b want %b", k, bus.req_ready, exp_g[k]);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (cyc - prev != 4) $display("FAIL rr_interval%0d: got %0d want 4", k, cyc - prev);
        else n_pass++;
      end
      prev = cyc;
      @(posedge clk); #1;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin
        @(posedge clk); #1; n++;
      end
      exp_y = exp_g[k][1] ? 16'h4FFF : 16'h1234;
      exp_o = exp_g[k][1];
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp_g[k][1] || bus.rsp_y !== exp_y || bus.rsp_ovf !== exp_o)
        $display("FAIL rr_rsp%0d: valid=%b id=%b y=%h ovf=%b want 1/%b/%h/%b", k, bus.rsp_valid, bus.rsp_id, bus.rsp_y, bus.rsp_ovf, exp_g[k][1], exp_y, exp_o);
      else n_pass++;
      if (k == 3) bus.req_valid = 2'b00;
      @(posedge clk);
    end
    #1;
  endtask

  task automatic test_backpressure;
    logic [1:0] g;
    bit seen;
    bus.rsp_ready = 1'b0;
    bus.req0_a = 16'hFFFE; bus.req0_b = 16'hFFFF; bus.req0_mod = 1'b1;  // 0xFFFE + 0x0000 + 1
    issue(2'b01, g);
    wait_rsp(seen);
    n_checks++;
    if (g !== 2'b01 || !seen || bus.rsp_y !== 16'hFFFF || bus.rsp_ovf !== 1'b0 || bus.rsp_id !== 1'b0)
      $display("FAIL bp_rsp: grant=%b seen=%0d y=%h ovf=%b id=%b want 01/1/ffff/0/0", g, seen, bus.rsp_y, bus.rsp_ovf, bus.rsp_id);
    else n_pass++;
    bus.req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_y !== 16'hFFFF || bus.rsp_ovf !== 1'b0 || bus.req_ready !== 2'b00)
        $display("FAIL bp_hold%0d: valid=%b y=%h ovf=%b req_ready=%b want 1/ffff/0/00", k, bus.rsp_valid, bus.rsp_y, bus.rsp_ovf, bus.req_ready);
      else n_pass++;
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL bp_release: valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [1:0] g;
    bit rose;
    bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_mod = 1'b0;
    issue(2'b01, g);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.csa_a !== 16'h0000 || bus.csa_b !== 16'h0000)
      $display("FAIL midrst_clear: busy=%b valid=%b a=%h b=%h want 0/0/0000/0000", bus.busy, bus.rsp_valid, bus.csa_a, bus.csa_b);
    else n_pass++;
    rose = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rose = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) rose = 1'b1;
    end
    n_checks++;
    if (rose !== 1'b0) $display("FAIL midrst_norsp: rsp_valid rose=%b want 0", rose);
    else n_pass++;
    bus.req_valid = 2'b11;
    #1;
    n_checks++;
    if (bus.req_ready !== 2'b01) $display("FAIL midrst_ptr: req_ready=%b want 01", bus.req_ready);
    else n_pass++;
    bus.req_valid = 2'b00;
    #1;
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.req_valid = 2'b00; bus.rsp_ready = 1'b1;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_mod = 1'b0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_mod = 1'b0;
    test_reset;
    test_single_add;
    test_carry;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
